// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment scan controller: state encoding,
// default digit count and the all-anodes-off pattern.
package seven_segment_pkg;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   localparam int DISP_DIGITS = 8;

   // Wide enough for any practical display; users truncate to their digit count.
   localparam logic [63:0] ANODE_OFF = '1;

endpackage

// File: rtl/seven_segment_scan.sv
// Time-multiplexed 7-segment scan: snapshots data/enables once per frame, then
// walks the digits with a SHOW window and an optional all-off BLANK gap each.
module seven_segment_scan
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS   = DISP_DIGITS,
   parameter int SHOW_CYCLES  = 100000,
   parameter int BLANK_CYCLES = 2000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] data_i,
   input  logic [NUM_DIGITS-1:0]   digit_en_i,
   output logic [3:0]              hex_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    frame_o
);

   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_MAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

   localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
   localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF     = NUM_DIGITS'(ANODE_OFF);

   state_t                  r_state, w_state_nxt;
   logic [IDX_W-1:0]        r_idx, w_idx_nxt;
   logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
   logic [4*NUM_DIGITS-1:0] r_shadow;
   logic [NUM_DIGITS-1:0]   r_en;
   logic                    w_adv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_LOAD;
         r_idx    <= '0;
         r_cnt    <= '0;
         r_shadow <= '0;
         r_en     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         if (r_state == ST_LOAD) begin
            r_shadow <= data_i;
            r_en     <= digit_en_i;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_adv       = 1'b0;
      case (r_state)
         ST_LOAD: begin
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_SHOW;
         end
         ST_SHOW: begin
            if (r_cnt == SHOW_LAST) begin
               w_cnt_nxt = '0;
               if (HAS_BLANK) w_state_nxt = ST_BLANK;
               else           w_adv       = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_BLANK: begin
            if (r_cnt == BLANK_LAST) begin
               w_cnt_nxt = '0;
               w_adv     = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = ST_LOAD;
      endcase
      // Last digit closes the frame; otherwise step to the next slot.
      if (w_adv) begin
         if (r_idx == IDX_LAST) begin
            w_state_nxt = ST_LOAD;
         end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = ST_SHOW;
         end
      end
   end

   always_comb begin
      an_o = AN_OFF;
      if (r_state == ST_SHOW) an_o[r_idx] = ~r_en[r_idx];
   end

   // Nibble follows idx, so it naturally holds through BLANK and reads 0 in reset.
   assign hex_o   = r_shadow[{r_idx, 2'b00} +: 4];
   assign frame_o = (r_state == ST_LOAD) & ~rst;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: two configurations checked cycle by cycle
// against a frame-offset arithmetic model of the scan.
module tb_seven_segment_scan;

   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   logic [31:0] data_a;
   logic [7:0]  en_a;
   logic [3:0]  hex_a;
   logic [7:0]  an_a;
   logic        frame_a;
   logic [15:0] data_b;
   logic [3:0]  en_b;
   logic [3:0]  hex_b;
   logic [3:0]  an_b;
   logic        frame_b;

   int n_chk  = 0;
   int n_fail = 0;
   int tA = 0, tB = 0;
   logic [31:0] mDA = '0;
   logic [7:0]  mEA = '0;
   logic [31:0] mDB = '0;
   logic [7:0]  mEB = '0;

   localparam int PA = 41;
   localparam int PB = 5;

   always #5 clk = ~clk;

   seven_segment_scan #(.NUM_DIGITS(8), .SHOW_CYCLES(4), .BLANK_CYCLES(1)) u_dut_a (
      .clk(clk), .rst(rst_a), .data_i(data_a), .digit_en_i(en_a),
      .hex_o(hex_a), .an_o(an_a), .frame_o(frame_a)
   );

   seven_segment_scan #(.NUM_DIGITS(4), .SHOW_CYCLES(1), .BLANK_CYCLES(0)) u_dut_b (
      .clk(clk), .rst(rst_b), .data_i(data_b), .digit_en_i(en_b),
      .hex_o(hex_b), .an_o(an_b), .frame_o(frame_b)
   );

   // Offset t=0 is the LOAD cycle; each digit then owns s+b cycles, SHOW first.
   function automatic logic [7:0] m_an(int t, int n, int s, int b, logic [7:0] e);
      int p, u, d, ph;
      p = 1 + n * (s + b);
      if (t % p == 0) return 8'hFF;
      u  = (t % p) - 1;
      d  = u / (s + b);
      ph = u % (s + b);
      if (ph < s && e[d]) return ~(8'd1 << d);
      return 8'hFF;
   endfunction

   function automatic logic [3:0] m_hex(int t, int n, int s, int b, logic [31:0] dat);
      int p, d;
      p = 1 + n * (s + b);
      d = ((t % p) - 1) / (s + b);
      return dat[4*d +: 4];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit which);
      @(negedge clk);
      if (!which) begin
         chk("an_a", 32'(an_a), 32'(m_an(tA, 8, 4, 1, mEA)));
         chk("frame_a", 32'(frame_a), 32'(tA % PA == 0));
         if (tA % PA != 0) chk("hex_a", 32'(hex_a), 32'(m_hex(tA, 8, 4, 1, mDA)));
      end else begin
         chk("an_b", 32'({4'hF, an_b}), 32'(m_an(tB, 4, 1, 0, mEB)));
         chk("frame_b", 32'(frame_b), 32'(tB % PB == 0));
         if (tB % PB != 0) chk("hex_b", 32'(hex_b), 32'(m_hex(tB, 4, 1, 0, mDB)));
      end
      @(posedge clk);
      if (!which) begin
         if (tA % PA == 0) begin mDA = data_a; mEA = en_a; end
         tA++;
      end else begin
         if (tB % PB == 0) begin mDB = {16'h0, data_b}; mEB = {4'hF, en_b}; end
         tB++;
      end
      #1;
   endtask

   initial begin
      rst_a  = 1'b1;
      rst_b  = 1'b1;
      data_a = 32'h89ABCDEF;
      en_a   = 8'hFF;
      data_b = 16'h4321;
      en_b   = 4'hF;
      #1;
      chk("rst_an_a", 32'(an_a), 32'h000000FF);
      chk("rst_hex_a", 32'(hex_a), 32'h0);
      chk("rst_frame_a", 32'(frame_a), 32'h0);
      chk("rst_an_b", 32'(an_b), 32'h0000000F);

      // scan order, two full frames
      @(posedge clk); #1;
      rst_a = 1'b0; tA = 0;
      repeat (2 * PA) cyc(0);

      // no tearing: switch data while digit 3 is being shown
      data_a = 32'h11111111;
      while (tA % PA != 17) cyc(0);
      data_a = 32'h22222222;
      repeat (PA + 5) cyc(0);

      // digit mask
      en_a = 8'h0F;
      repeat (2 * PA) cyc(0);

      // random inputs changing every cycle
      repeat (240) begin
         data_a = $urandom;
         en_a   = 8'($urandom);
         cyc(0);
      end

      // reset during SHOW of digit 5
      en_a = 8'hFF;
      while (tA % PA != 27) cyc(0);
      #2;
      rst_a = 1'b1;
      #1;
      chk("midrst_an_a", 32'(an_a), 32'h000000FF);
      chk("midrst_hex_a", 32'(hex_a), 32'h0);
      chk("midrst_frame_a", 32'(frame_a), 32'h0);
      data_a = $urandom;
      @(posedge clk); #1;
      rst_a = 1'b0; tA = 0;
      repeat (PA + 4) cyc(0);

      // no-blank, single-cycle configuration
      @(posedge clk); #1;
      rst_b = 1'b0; tB = 0;
      repeat (3 * PB) cyc(1);
      en_b = 4'hA;
      repeat (2 * PB) cyc(1);
      repeat (30) begin
         data_b = 16'($urandom);
         en_b   = 4'($urandom);
         cyc(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
